// File: rtl/nx_ram_sw_arbiter.sv
// nx_ram_sw_arbiter: shares one single-port RAM between the functional datapath and the
// software indirect-access controller, tagging reads so responses return to their owner.
module nx_ram_sw_arbiter #(
    parameter int N_DATA_BITS   = 32,
    parameter int N_ENTRIES     = 1024,
    parameter int RD_LATENCY    = 1,
    parameter int N_STARVE_BITS = 4,
    localparam int AW           = $clog2(N_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hw_req,
    input  logic                   hw_we,
    input  logic [AW-1:0]          hw_add,
    input  logic [N_DATA_BITS-1:0] hw_wdat,
    output logic                   hw_gnt,
    output logic                   hw_rsp,
    output logic [N_DATA_BITS-1:0] hw_rdat,
    input  logic                   sw_cs,
    input  logic                   sw_ce,
    input  logic                   sw_we,
    input  logic [AW-1:0]          sw_add,
    input  logic [N_DATA_BITS-1:0] sw_wdat,
    input  logic                   yield,
    input  logic                   reset,
    output logic                   grant,
    output logic                   rsp,
    output logic [N_DATA_BITS-1:0] sw_rdat,
    output logic                   mem_cs,
    output logic                   mem_ce,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_add,
    output logic [N_DATA_BITS-1:0] mem_wdat,
    input  logic [N_DATA_BITS-1:0] mem_rdat
);
    localparam int LAST = RD_LATENCY - 1;

    logic [N_STARVE_BITS-1:0] wait_cnt;
    logic [RD_LATENCY-1:0]    tag_v;
    logic [RD_LATENCY-1:0]    tag_o;
    logic                     sw_pri;
    logic                     rd_issue;

    assign sw_pri   = yield | reset | (&wait_cnt);
    // Gating with rst_n keeps the RAM strobes quiet while the block is held in reset.
    assign grant    = rst_n & sw_cs & (sw_pri | !hw_req);
    assign hw_gnt   = rst_n & hw_req & !grant;
    assign mem_cs   = grant | hw_gnt;
    assign mem_we   = grant ? sw_we : (hw_gnt & hw_we);
    assign mem_ce   = grant & sw_ce;
    assign mem_add  = grant ? sw_add  : (hw_gnt ? hw_add  : '0);
    assign mem_wdat = grant ? sw_wdat : (hw_gnt ? hw_wdat : '0);
    assign rd_issue = mem_cs & (!mem_we | mem_ce);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            tag_v    <= '0;
            tag_o    <= '0;
            rsp      <= 1'b0;
            hw_rsp   <= 1'b0;
            sw_rdat  <= '0;
            hw_rdat  <= '0;
        end else begin
            wait_cnt <= (!sw_cs || grant) ? '0 : (&wait_cnt ? wait_cnt : wait_cnt + 1'b1);
            tag_v[0] <= rd_issue;
            tag_o[0] <= grant;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_o[i] <= tag_o[i-1];
            end
            rsp    <= tag_v[LAST] & tag_o[LAST];
            hw_rsp <= tag_v[LAST] & !tag_o[LAST];
            if (tag_v[LAST] && tag_o[LAST])
                sw_rdat <= mem_rdat;
            if (tag_v[LAST] && !tag_o[LAST])
                hw_rdat <= mem_rdat;
        end
    end
endmodule

// File: tb/tb_nx_ram_sw_arbiter.sv
// tb_nx_ram_sw_arbiter: directed vectors and cycle sequences for nx_ram_sw_arbiter
// at RD_LATENCY 2 (u2) and 3 (u3).
module tb_nx_ram_sw_arbiter;
    localparam int DW = 32;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic hw_req, hw_we, sw_cs, sw_ce, sw_we, yld, sw_reset;
    logic [AW-1:0] hw_add, sw_add;
    logic [DW-1:0] hw_wdat, sw_wdat, mem_rdat;

    logic hw_gnt, hw_rsp, grant, rsp, mem_cs, mem_ce, mem_we;
    logic [DW-1:0] hw_rdat, sw_rdat, mem_wdat;
    logic [AW-1:0] mem_add;

    logic hw_gnt3, hw_rsp3, grant3, rsp3, mem_cs3, mem_ce3, mem_we3;
    logic [DW-1:0] hw_rdat3, sw_rdat3, mem_wdat3;
    logic [AW-1:0] mem_add3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nx_ram_sw_arbiter #(.N_DATA_BITS(DW), .N_ENTRIES(1024), .RD_LATENCY(2), .N_STARVE_BITS(4)) u2 (
        .clk(clk), .rst_n(rst_n),
        .hw_req(hw_req), .hw_we(hw_we), .hw_add(hw_add), .hw_wdat(hw_wdat),
        .hw_gnt(hw_gnt), .hw_rsp(hw_rsp), .hw_rdat(hw_rdat),
        .sw_cs(sw_cs), .sw_ce(sw_ce), .sw_we(sw_we), .sw_add(sw_add), .sw_wdat(sw_wdat),
        .yield(yld), .reset(sw_reset), .grant(grant), .rsp(rsp), .sw_rdat(sw_rdat),
        .mem_cs(mem_cs), .mem_ce(mem_ce), .mem_we(mem_we), .mem_add(mem_add),
        .mem_wdat(mem_wdat), .mem_rdat(mem_rdat)
    );

    nx_ram_sw_arbiter #(.N_DATA_BITS(DW), .N_ENTRIES(1024), .RD_LATENCY(3), .N_STARVE_BITS(4)) u3 (
        .clk(clk), .rst_n(rst_n),
        .hw_req(hw_req), .hw_we(hw_we), .hw_add(hw_add), .hw_wdat(hw_wdat),
        .hw_gnt(hw_gnt3), .hw_rsp(hw_rsp3), .hw_rdat(hw_rdat3),
        .sw_cs(sw_cs), .sw_ce(sw_ce), .sw_we(sw_we), .sw_add(sw_add), .sw_wdat(sw_wdat),
        .yield(yld), .reset(sw_reset), .grant(grant3), .rsp(rsp3), .sw_rdat(sw_rdat3),
        .mem_cs(mem_cs3), .mem_ce(mem_ce3), .mem_we(mem_we3), .mem_add(mem_add3),
        .mem_wdat(mem_wdat3), .mem_rdat(mem_rdat)
    );

    typedef struct packed {
        logic          hw_req;
        logic          hw_we;
        logic [AW-1:0] hw_add;
        logic [DW-1:0] hw_wdat;
        logic          sw_cs;
        logic          sw_ce;
        logic          sw_we;
        logic [AW-1:0] sw_add;
        logic [DW-1:0] sw_wdat;
        logic          yld;
        logic          rst;
        logic [4:0]    exp_flags;
        logic [AW-1:0] exp_add;
        logic [DW-1:0] exp_wdat;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hw_req = 0; hw_we = 0; hw_add = '0; hw_wdat = '0;
        sw_cs = 0; sw_ce = 0; sw_we = 0; sw_add = '0; sw_wdat = '0;
        yld = 0; sw_reset = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            idle();
        end
    endtask

    initial begin
        int grants, hwgs, resps;
        // flags: grant, hw_gnt, mem_cs, mem_ce, mem_we
        vecs[0] = '{0,0,10'h000,32'h0,        0,0,0,10'h000,32'h0,    0,0, 5'b00000, 10'h000, 32'h0};
        vecs[1] = '{1,0,10'h055,32'h1111,     0,0,0,10'h000,32'h0,    0,0, 5'b01100, 10'h055, 32'h1111};
        vecs[2] = '{1,1,10'h3ff,32'hDEADBEEF, 0,0,0,10'h000,32'h0,    0,0, 5'b01101, 10'h3ff, 32'hDEADBEEF};
        vecs[3] = '{0,0,10'h000,32'h0,        1,0,0,10'h012,32'h0,    0,0, 5'b10100, 10'h012, 32'h0};
        vecs[4] = '{1,0,10'h020,32'hAAAA,     1,0,1,10'h030,32'hBBBB, 0,0, 5'b01100, 10'h020, 32'hAAAA};
        vecs[5] = '{1,0,10'h020,32'hAAAA,     1,0,1,10'h030,32'hBBBB, 1,0, 5'b10101, 10'h030, 32'hBBBB};
        vecs[6] = '{1,0,10'h020,32'hAAAA,     1,0,1,10'h030,32'hBBBB, 0,1, 5'b10101, 10'h030, 32'hBBBB};
        vecs[7] = '{0,0,10'h000,32'h0,        1,1,1,10'h040,32'hCCCC, 0,0, 5'b10111, 10'h040, 32'hCCCC};
        vecs[8] = '{1,1,10'h050,32'hDDDD,     0,1,0,10'h000,32'h0,    0,0, 5'b01101, 10'h050, 32'hDDDD};
        vecs[9] = '{0,0,10'h000,32'h0,        0,0,0,10'h000,32'h0,    1,0, 5'b00000, 10'h000, 32'h0};

        idle();
        mem_rdat = 32'h5555_5555;
        rst_n = 0;
        tick();
        sw_cs = 1;
        #1;
        chk("reset_regs", {rsp, hw_rsp, sw_rdat, hw_rdat}, '0);
        chk("reset_comb", {grant, hw_gnt, mem_cs, mem_we, mem_ce, mem_add}, '0);
        tick();
        idle();
        rst_n = 1;

        for (int i = 0; i < 10; i++) begin
            tick();
            {hw_req, hw_we, hw_add, hw_wdat} = {vecs[i].hw_req, vecs[i].hw_we, vecs[i].hw_add, vecs[i].hw_wdat};
            {sw_cs, sw_ce, sw_we, sw_add, sw_wdat} = {vecs[i].sw_cs, vecs[i].sw_ce, vecs[i].sw_we, vecs[i].sw_add, vecs[i].sw_wdat};
            {yld, sw_reset} = {vecs[i].yld, vecs[i].rst};
            #1;
            chk($sformatf("vec%0d", i), {grant, hw_gnt, mem_cs, mem_ce, mem_we, mem_add, mem_wdat},
                {vecs[i].exp_flags, vecs[i].exp_add, vecs[i].exp_wdat});
        end
        idle_cycles(6);

        // software read at 0x12, data on the bus only in the cycle the RAM presents it
        for (int c = 0; c < 6; c++) begin
            tick();
            idle();
            sw_cs = (c == 0);
            sw_add = 10'h012;
            mem_rdat = (c == 2) ? 32'hA5A5A5A5 : 32'h0;
            #1;
            if (c == 0) chk("rd_grant", {grant, hw_gnt, mem_cs, mem_add}, {1'b1, 1'b0, 1'b1, 10'h012});
            chk($sformatf("rd_rsp_c%0d", c), {rsp, hw_rsp}, {(c == 3), 1'b0});
            if (c >= 3) chk($sformatf("rd_data_c%0d", c), sw_rdat, 32'hA5A5A5A5);
        end

        // starvation: continuous hw_req, sw_cs held through one grant and one cycle past it
        for (int c = 0; c < 18; c++) begin
            tick();
            idle();
            hw_req = 1; hw_add = 10'h001;
            sw_cs = (c < 17); sw_add = 10'h2aa;
            #1;
            chk($sformatf("starve_c%0d", c), {grant, hw_gnt, mem_add},
                {(c == 15), (c != 15), (c == 15) ? 10'h2aa : 10'h001});
        end
        idle_cycles(6);

        // reset sweep: software writes win every cycle, no responses
        grants = 0; hwgs = 0; resps = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            idle();
            if (c < 16) begin
                sw_reset = 1; hw_req = 1; sw_cs = 1; sw_we = 1;
                sw_add = AW'(c); sw_wdat = '0;
            end
            #1;
            grants += int'(grant);
            hwgs += int'(hw_gnt);
            resps += int'(rsp) + int'(hw_rsp);
        end
        chk("sweep_grants", grants, 16);
        chk("sweep_hw_gnt", hwgs, 0);
        chk("sweep_rsp", resps, 0);

        // alternating hw/sw reads, checked on the RD_LATENCY=3 instance
        for (int c = 0; c < 10; c++) begin
            tick();
            idle();
            hw_req = (c == 0 || c == 2);
            sw_cs = (c == 1 || c == 3);
            mem_rdat = 32'h1000_0000 + DW'(c);
            #1;
            chk($sformatf("alt_rsp_c%0d", c), {hw_rsp3, rsp3}, {(c == 4 || c == 6), (c == 5 || c == 7)});
            if (c == 4) chk("alt_hw0", hw_rdat3, 32'h1000_0003);
            if (c == 5) chk("alt_sw0", sw_rdat3, 32'h1000_0004);
            if (c == 6) chk("alt_hw1", hw_rdat3, 32'h1000_0005);
            if (c == 7) chk("alt_sw1", sw_rdat3, 32'h1000_0006);
        end
        idle_cycles(2);

        // rst_n pulse one cycle after a software read grant
        tick();
        idle();
        sw_cs = 1; sw_add = 10'h005;
        mem_rdat = 32'hBAD0BAD0;
        #1;
        chk("rst_rd_grant", grant, 1'b1);
        tick();
        rst_n = 0;
        #1;
        chk("rst_mid_comb", {grant, mem_cs}, 2'b00);
        chk("rst_mid_regs", {rsp, sw_rdat}, '0);
        tick();
        idle();
        rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            #1;
            chk($sformatf("rst_after_c%0d", c), {rsp, sw_rdat}, '0);
        end
        mem_rdat = 32'h600DF00D;
        for (int c = 0; c < 5; c++) begin
            tick();
            idle();
            sw_cs = (c == 0); sw_add = 10'h007;
            #1;
            chk($sformatf("rst_next_c%0d", c), rsp, (c == 3));
            if (c == 3) chk("rst_next_data", sw_rdat, 32'h600DF00D);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nx_ram_sw_arbiter.md
# nx_ram_sw_arbiter

Arbitrates one single-port RAM between the functional (hardware) datapath and the software indirect-access controller that sits directly upstream on the sw_* side. Produces the controller's grant and rsp handshakes and returns registered read data. Hardware normally wins. Software wins when it asserts yield, holds reset, or has waited the starvation limit.

## Interface
Parameters:
- N_DATA_BITS, 32: RAM word width.
- N_ENTRIES, 1024: RAM depth; address width is clog2(N_ENTRIES).
- RD_LATENCY, 1: RAM read latency in cycles from mem_cs to mem_rdat valid; legal range 1..4.
- N_STARVE_BITS, 4: width of the software wait counter; the limit is all-ones.

Ports (clock/reset: one clock; reset is asynchronous and active-low):
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- hw_req  in  1  functional access request, single cycle, not held.
- hw_we  in  1  functional write when high, read when low.
- hw_add  in  clog2(N_ENTRIES)  functional address.
- hw_wdat  in  N_DATA_BITS  functional write data.
- hw_gnt  out  1  combinational; functional access accepted this cycle.
- hw_rsp  out  1  functional read data valid pulse.
- hw_rdat  out  N_DATA_BITS  functional read data, held until next hw_rsp.
- sw_cs  in  1  software request, held until grant.
- sw_ce  in  1  software compare; treated as a read for response purposes.
- sw_we  in  1  software write.
- sw_add  in  clog2(N_ENTRIES)  software address.
- sw_wdat  in  N_DATA_BITS  software write data.
- yield  in  1  software demands priority.
- reset  in  1  software reset/init sweep in progress.
- grant  out  1  combinational; software access accepted this cycle.
- rsp  out  1  software read/compare data valid pulse.
- sw_rdat  out  N_DATA_BITS  software read data, held until next rsp.
- mem_cs, mem_ce, mem_we  out  1  RAM strobes, combinational from the winner.
- mem_add  out  clog2(N_ENTRIES)  RAM address.
- mem_wdat  out  N_DATA_BITS  RAM write data.
- mem_rdat  in  N_DATA_BITS  RAM read data, RD_LATENCY cycles after mem_cs.

## Operation
- sw_pri = yield | reset | (wait_cnt == all-ones).
- grant = sw_cs & (sw_pri | !hw_req).
- hw_gnt = hw_req & !grant.
- Exactly one of grant and hw_gnt is high, or neither is.
- A dropped functional request is the functional client's responsibility; it must re-request if hw_gnt is low.
- RAM outputs follow the winner:
  - mem_cs = grant | hw_gnt.
  - mem_we = grant ? sw_we : hw_we.
  - mem_ce = grant & sw_ce.
  - mem_add and mem_wdat are taken from the winner. They are zero when idle.
- wait_cnt:
  - Increments, saturating, each cycle that sw_cs is high and grant is low.
  - Clears on grant, and when sw_cs is low.
- Read tag pipeline is RD_LATENCY stages deep. Each stage holds {valid, owner}.
  - Stage 0 loads valid = mem_cs & (!mem_we | mem_ce), owner = grant.
  - Stages shift every cycle.
- At the last stage, if valid:
  - owner = sw: sw_rdat <= mem_rdat and rsp <= 1.
  - owner = hw: hw_rdat <= mem_rdat and hw_rsp <= 1.
- rsp and hw_rsp are otherwise 0, so each is a one-cycle pulse per read.
- Writes produce no response.
- Pipeline tags are independent per cycle, so back-to-back reads from mixed owners all return in order.

## Timing
- Grant/hw_gnt: same cycle as the request (combinational).
- Read response: rsp or hw_rsp is high RD_LATENCY+1 cycles after the grant cycle, with data valid that cycle.
- Guaranteed software service: a held sw_cs is granted no later than 2^N_STARVE_BITS cycles after assertion, even under continuous hw_req.
- Reset values: hw_rsp=0, rsp=0, hw_rdat=0, sw_rdat=0, wait_cnt=0, all pipeline valids=0.
- Combinational outputs (grant, hw_gnt, mem_*) follow inputs and are 0 under reset.
- Reset mid-read: in-flight tags are discarded and no rsp is issued after rst_n rises.
- sw_cs and hw_req both high with sw_pri low: hw wins and wait_cnt increments.
- At saturation, sw wins that cycle and wait_cnt clears the next cycle.
- reset held high: every held sw_cs cycle is granted; hw_gnt stays 0 for the whole sweep.
- sw_ce with sw_we both high: treated as a compare (response generated).

## Test plan
- Idle RAM, RD_LATENCY=2, software read of addr 0x12 with mem_rdat=0xA5A5A5A5: grant in cycle 0, rsp in cycle 3, sw_rdat=0xA5A5A5A5 held afterwards.
- Continuous hw_req with sw_cs held, N_STARVE_BITS=4: grant on cycle 15 exactly; hw_gnt low that cycle and high on all other cycles.
- hw_req and sw_cs together, yield=1: grant=1, hw_gnt=0; mem_add equals sw_add.
- reset=1 with a 16-entry sweep of held sw_cs write cycles and hw_req continuously high: 16 grants, no hw_gnt, no rsp.
- Alternating hw/sw reads on consecutive cycles, RD_LATENCY=3: rsp and hw_rsp alternate starting at cycle 4, each carrying its own mem_rdat.
- rst_n pulsed low one cycle after a software read grant: rsp never asserts, sw_rdat=0, next read completes normally.
